dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port `data_memory`. It lets two requesters share the one memory port. Requester 0 is the pipeline MEM stage; requester 1 is a debug/load port. It grants them round-robin, drives `MemRead`/`MemWrite`/`address`/`write_data` for exactly one access cycle, captures `read_data`, and returns a registered response with a range/alignment error flag.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port data memory between
// the pipeline MEM stage (port 0) and a debug/load port (port 1).
module dmem_arbiter #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int unsigned AW = 32;
  localparam logic [AW-1:0] WORD_LIMIT = AW'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            win_q, win_d;
  logic            op_q, op_d;
  logic            err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   wdata_q, wdata_d;
  logic [1:0]      resp_valid_q, resp_valid_d;
  logic [1:0]      resp_err_q, resp_err_d;
  logic [AW-1:0]   resp0_rdata_q, resp0_rdata_d;
  logic [AW-1:0]   resp1_rdata_q, resp1_rdata_d;

  logic            any_req;
  logic            pick1;
  logic            sel_write;
  logic [AW-1:0]   sel_addr;
  logic [AW-1:0]   sel_wdata;
  logic            sel_err;
  logic [AW-1:0]   load_data;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign any_req   = req0_valid | req1_valid;
  assign pick1     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_write = pick1 ? req1_write : req0_write;
  assign sel_addr  = pick1 ? req1_addr  : req0_addr;
  assign sel_wdata = pick1 ? req1_wdata : req0_wdata;
  assign sel_err   = (sel_addr[1:0] != 2'b00) | ((sel_addr >> 2) >= WORD_LIMIT);
  assign load_data = (~op_q & ~err_q) ? mem_read_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      win_q         <= 1'b0;
      op_q          <= 1'b0;
      err_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      resp_valid_q  <= '0;
      resp_err_q    <= '0;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      win_q         <= win_d;
      op_q          <= op_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp0_rdata_q <= resp0_rdata_d;
      resp1_rdata_q <= resp1_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    win_d          = win_q;
    op_d           = op_q;
    err_d          = err_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    resp_valid_d   = resp_valid_q;
    resp_err_d     = resp_err_q;
    resp0_rdata_d  = resp0_rdata_q;
    resp1_rdata_d  = resp1_rdata_q;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    unique case (state_q)
      IDLE: begin
        if (reset_n && any_req) begin
          req0_ready   = ~pick1;
          req1_ready   = pick1;
          win_d        = pick1;
          op_d         = sel_write;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = sel_err;
          last_grant_d = pick1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Erroneous requests present the address but never strobe the memory.
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        mem_write      = op_q & ~err_q;
        mem_read       = ~op_q & ~err_q;
        resp_valid_d   = win_q ? 2'b10 : 2'b01;
        resp_err_d     = win_q ? {err_q, 1'b0} : {1'b0, err_q};
        resp0_rdata_d  = win_q ? '0 : load_data;
        resp1_rdata_d  = win_q ? load_data : '0;
        state_d        = RESP;
      end
      RESP: begin
        resp_valid_d  = '0;
        resp_err_d    = '0;
        resp0_rdata_d = '0;
        resp1_rdata_d = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_err   = resp_err_q[0];
  assign resp1_err   = resp_err_q[1];
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model of grants, access timing and
// memory contents, checked against the DUT every cycle.
module tb_dmem_arbiter;
  localparam int unsigned MEM_WORDS = 64;

  logic clk, reset_n, clr;
  logic r0_valid, r0_write, r1_valid, r1_write;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [MEM_WORDS];

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  item_t q0[$], q1[$];

  // Model: age counts cycles since the last accept (0 = arbiter free).
  int          age, last, tw, cyc;
  bit          twr, terr, acc0, acc1;
  logic [31:0] taddr, twdata, trdata;
  logic [31:0] ref_mem [MEM_WORDS];
  int          grants[$], acc_cyc[$];
  logic [31:0] last_rdata0, last_rdata1;
  bit          last_err0, last_err1;
  int          strobe_cnt;
  int          tests, fails;

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(r0_valid), .req0_write(r0_write), .req0_addr(r0_addr), .req0_wdata(r0_wdata),
    .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(r1_valid), .req1_write(r1_write), .req1_addr(r1_addr), .req1_wdata(r1_wdata),
    .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Single-port memory: store commits on the falling edge, read is combinational.
  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (mem_write && mem_address[31:8] == 24'h0) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end
  assign mem_read_data = (mem_address[31:8] == 24'h0) ? mem[mem_address[7:2]] : 32'hA5A5_A5A5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int winner(input bit v0, input bit v1, input int lst);
    if (v0 && v1) return 1 - lst;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= MEM_WORDS);
  endfunction

  task automatic check_all_zero(input string tag);
    chkb({tag, "_ready0"}, req0_ready, 1'b0);
    chkb({tag, "_ready1"}, req1_ready, 1'b0);
    chkb({tag, "_resp0_valid"}, resp0_valid, 1'b0);
    chkb({tag, "_resp1_valid"}, resp1_valid, 1'b0);
    chkb({tag, "_resp0_err"}, resp0_err, 1'b0);
    chkb({tag, "_resp1_err"}, resp1_err, 1'b0);
    chk({tag, "_resp0_rdata"}, resp0_rdata, 32'h0);
    chk({tag, "_resp1_rdata"}, resp1_rdata, 32'h0);
    chkb({tag, "_mem_read"}, mem_read, 1'b0);
    chkb({tag, "_mem_write"}, mem_write, 1'b0);
    chk({tag, "_mem_address"}, mem_address, 32'h0);
    chk({tag, "_mem_write_data"}, mem_write_data, 32'h0);
  endtask

  task automatic compare();
    int  w;
    bit  acc, rsp;
    if (mem_read || mem_write) strobe_cnt++;
    if (resp0_valid) begin last_rdata0 = resp0_rdata; last_err0 = resp0_err; end
    if (resp1_valid) begin last_rdata1 = resp1_rdata; last_err1 = resp1_err; end
    if (!reset_n) begin
      check_all_zero("rst");
      return;
    end
    w   = (age == 0) ? winner(r0_valid, r1_valid, last) : -1;
    acc = (age == 1);
    rsp = (age == 2);
    chkb("ready0", req0_ready, w == 0);
    chkb("ready1", req1_ready, w == 1);
    chkb("mem_write", mem_write, acc && twr && !terr);
    chkb("mem_read", mem_read, acc && !twr && !terr);
    chk("mem_address", mem_address, acc ? taddr : 32'h0);
    chk("mem_write_data", mem_write_data, acc ? twdata : 32'h0);
    chkb("resp0_valid", resp0_valid, rsp && tw == 0);
    chkb("resp1_valid", resp1_valid, rsp && tw == 1);
    if (rsp && tw == 0) begin
      chk("resp0_rdata", resp0_rdata, trdata);
      chkb("resp0_err", resp0_err, terr);
    end
    if (rsp && tw == 1) begin
      chk("resp1_rdata", resp1_rdata, trdata);
      chkb("resp1_err", resp1_err, terr);
    end
  endtask

  task automatic model_step();
    int w;
    acc0 = 0;
    acc1 = 0;
    cyc++;
    if (!reset_n) return;
    if (age == 0) begin
      w = winner(r0_valid, r1_valid, last);
      if (w >= 0) begin
        tw     = w;
        twr    = (w == 0) ? r0_write : r1_write;
        taddr  = (w == 0) ? r0_addr : r1_addr;
        twdata = (w == 0) ? r0_wdata : r1_wdata;
        terr   = is_err(taddr);
        last   = w;
        grants.push_back(w);
        acc_cyc.push_back(cyc);
        acc0   = (w == 0);
        acc1   = (w == 1);
        age    = 1;
      end
    end else if (age == 1) begin
      if (twr && !terr) ref_mem[taddr[7:2]] = twdata;
      trdata = (!twr && !terr) ? ref_mem[taddr[7:2]] : 32'h0;
      age = 2;
    end else begin
      age = 0;
    end
  endtask

  task automatic drive_step();
    item_t it;
    if (acc0 || !r0_valid) begin
      if (q0.size() > 0) begin
        it = q0.pop_front();
        r0_valid = 1'b1; r0_write = it.write; r0_addr = it.addr; r0_wdata = it.wdata;
      end else r0_valid = 1'b0;
    end
    if (acc1 || !r1_valid) begin
      if (q1.size() > 0) begin
        it = q1.pop_front();
        r1_valid = 1'b1; r1_write = it.write; r1_addr = it.addr; r1_wdata = it.wdata;
      end else r1_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
    drive_step();
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cycle();
      done = (q0.size() == 0 && q1.size() == 0 && !r0_valid && !r1_valid && age == 0);
    end
    chkb({tag, "_drain_timeout"}, done, 1'b1);
  endtask

  function automatic item_t rand_item();
    item_t it;
    int    k;
    k = $urandom_range(0, 9);
    it.write = 1'($urandom_range(0, 1));
    it.wdata = $urandom;
    case (k)
      0: it.addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      1: it.addr = 32'(256 + $urandom_range(0, 1023) * 4);
      2: it.addr = 32'h0000_00FC;
      3: it.addr = 32'h0000_0100;
      default: it.addr = 32'($urandom_range(0, 63) * 4);
    endcase
    return it;
  endfunction

  initial begin
    int exp6 [6];
    exp6 = '{0, 1, 0, 1, 0, 1};
    tests = 0; fails = 0; cyc = 0; strobe_cnt = 0;
    clk = 0; reset_n = 0; clr = 1;
    r0_valid = 0; r0_write = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_write = 0; r1_addr = 0; r1_wdata = 0;
    age = 0; last = 1; tw = 0; twr = 0; terr = 0; taddr = 0; twdata = 0; trdata = 0;
    last_rdata0 = 0; last_rdata1 = 0; last_err0 = 0; last_err1 = 0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;

    repeat (3) cycle();
    clr = 0;
    reset_n = 1;

    // Tie straight after reset: port 0 first, port 1 three cycles later.
    q0.push_back('{1'b0, 32'h0, 32'h0});
    q1.push_back('{1'b0, 32'h4, 32'h0});
    drain("tie");
    chk("tie_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("tie_first", 32'(grants[0]), 32'd0);
      chk("tie_second", 32'(grants[1]), 32'd1);
      chk("tie_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    end

    // Fairness with both held valid.
    grants.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{1'b0, 32'(8 * i), 32'h0});
      q1.push_back('{1'b0, 32'(8 * i + 4), 32'h0});
    end
    drain("fair");
    chk("fair_count", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++) chk("fair_order", 32'(grants[i]), 32'(exp6[i]));

    // Store then load on port 0.
    q0.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
    drain("store");
    chkb("store_err", last_err0, 1'b0);
    q0.push_back('{1'b0, 32'h10, 32'h0});
    drain("load");
    chk("load_data", last_rdata0, 32'hDEAD_BEEF);
    chkb("load_err", last_err0, 1'b0);

    // Misaligned store and out-of-range load on port 1.
    strobe_cnt = 0;
    last_rdata1 = 32'hFFFF_FFFF;
    q1.push_back('{1'b1, 32'h102, 32'hCAFE_F00D});
    drain("err_store");
    chkb("err_store_flag", last_err1, 1'b1);
    chk("err_store_rdata", last_rdata1, 32'h0);
    last_rdata1 = 32'hFFFF_FFFF;
    last_err1 = 0;
    q1.push_back('{1'b0, 32'h100, 32'h0});
    drain("err_load");
    chkb("err_load_flag", last_err1, 1'b1);
    chk("err_load_rdata", last_rdata1, 32'h0);
    chk("err_strobes", 32'(strobe_cnt), 32'd0);
    chk("err_word0", mem[0], 32'h0);

    // Reset during the high phase of a store's access cycle.
    q0.push_back('{1'b1, 32'h8, 32'h1234_5678});
    for (int i = 0; i < 20 && age != 1; i++) cycle();
    chk("rst_reach_access", 32'(age), 32'd1);
    reset_n = 0;
    age = 0;
    last = 1;
    #1;
    check_all_zero("midrst");
    cycle();
    cycle();
    chk("rst_word2", mem[2], 32'h0);
    reset_n = 1;
    grants.delete();
    q0.push_back('{1'b0, 32'h8, 32'h0});
    q1.push_back('{1'b0, 32'hC, 32'h0});
    drain("rst_tie");
    if (grants.size() > 0) chk("rst_tie_first", 32'(grants[0]), 32'd0);
    else chk("rst_tie_count", 32'(grants.size()), 32'd2);

    // Idle hold.
    strobe_cnt = 0;
    repeat (10) cycle();
    chk("idle_strobes", 32'(strobe_cnt), 32'd0);

    // Random traffic: back-to-back bursts, then sporadic arrivals.
    for (int i = 0; i < 40; i++) begin
      q0.push_back(rand_item());
      q1.push_back(rand_item());
    end
    drain("rand_burst");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) q0.push_back(rand_item());
      if ($urandom_range(0, 4) == 0) q1.push_back(rand_item());
      cycle();
    end
    drain("rand_mix");
    for (int i = 0; i < MEM_WORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
